wb_spi_flash_reader: RTL
========================

// Module: wb_spi_flash_reader
// PURPOSE
//  Wishbone classic slave that answers CPU reads by fetching 32-bit words from
//  an external SPI NOR flash using the READ (0x03) command, SPI mode 0. It sits
//  on a free wb_conmax slave port and drives the board flash pins
//  (ncs/dclk/mosi/miso). Writes are acknowledged and discarded.
// PARAMETERS
//  CLK_DIV  2  wb_clk_i cycles per dclk half-period (>=1); one SPI bit = 2*CLK_DIV cycles
//  CS_GAP   4  minimum wb_clk_i cycles ncs stays high between two flash transactions (>=1)
// PORTS
//  wb_clk_i  in   1   single clock, all logic on rising edge
//  wb_rst_i  in   1   reset, synchronous, active-high
//  wb_adr_i  in   32  byte address; [23:2] used, [1:0] treated as 00
//  wb_dat_i  in   32  write data (ignored)
//  wb_dat_o  out  32  read data, valid while wb_ack_o=1
//  wb_sel_i  in   4   byte select (ignored; full word always returned)
//  wb_we_i   in   1   1=write, 0=read
//  wb_stb_i  in   1   strobe
//  wb_cyc_i  in   1   bus cycle
//  wb_ack_o  out  1   one-cycle acknowledge
//  ncs       out  1   flash chip select, active-low
//  dclk      out  1   SPI clock, idle low
//  mosi      out  1   SPI data to flash
//  miso      in   1   SPI data from flash
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE, ncs=1, dclk=0, mosi=0, wb_ack_o=0,
//   wb_dat_o=0, counters=0. Takes effect on the next edge, aborting any transfer.
//  States: IDLE, WACK, SHIFT, DONE, GAP.
//  IDLE: req = wb_cyc_i & wb_stb_i.
//   req & we -> WACK; req & !we -> latch {adr[23:2],2'b00}, load 64-bit shift word
//   {8'h03, addr24, 32'h0}, set ncs=0, mosi=bit63 -> SHIFT.
//  WACK: wb_ack_o=1 for exactly one cycle -> IDLE; no SPI activity.
//  SHIFT: 64 bits, MSB first. Per bit: dclk low CLK_DIV cycles, then high CLK_DIV cycles.
//   miso sampled on the cycle dclk rises; mosi updates on the cycle dclk falls.
//   Bits 0..31 send cmd+addr; bits 32..63 capture data (mosi driven 0).
//  Byte order: flash byte at addr+k -> wb_dat_o[8k+7:8k], each byte received MSB first.
//  DONE: reached after the last high half-period; ncs=1, dclk=0, wb_ack_o=1 for
//   one cycle with assembled word on wb_dat_o -> GAP.
//   Latency: read accepted at edge N -> ncs low from N+1, ack in cycle N+1+128*CLK_DIV.
//  GAP: ncs=1 for CS_GAP cycles, then IDLE; requests pending meanwhile wait (no ack).
//  Abort: wb_cyc_i or wb_stb_i low during SHIFT -> next cycle ncs=1, dclk=0,
//   no ack, -> GAP. wb_dat_o keeps its previous value.
//  Master holding stb after ack is treated as a new request; never two acks per request.
//  wb_dat_o changes only in DONE or on reset. ack is never asserted with cyc low.
// TESTING
//  1 Read 0x00000104, flash model bytes 11,22,33,44 at 0x104..0x107, CLK_DIV=2 -> mosi
//    carries 0x03,0x00,0x01,0x04; wb_dat_o=0x44332211; ack high one cycle at N+257.
//  2 Write 0x00000010 data 0xDEADBEEF -> ack one cycle later for one cycle;
//    ncs stays 1, dclk stays 0 throughout.
//  3 Read, drop wb_cyc_i during address phase -> ncs=1 next cycle, no ack; following
//    read of 0x0 returns correct word.
//  4 Back-to-back reads 0x0 then 0x4 with stb held -> two acks, correct words,
//    ncs high >= CS_GAP cycles between transactions.
//  5 Assert wb_rst_i during data phase -> next cycle ncs=1, dclk=0, ack=0, wb_dat_o=0.
//  6 CLK_DIV=1, CS_GAP=1 rebuild, read 0x00000104 -> 0x44332211, ack at N+129.

Source files
------------

// File: rtl/wb_spi_flash_reader.sv
// Wishbone classic slave that serves 32-bit reads from an SPI NOR flash using
// the READ (0x03) command in SPI mode 0; writes are acknowledged and dropped.
module wb_spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        ncs,
  output logic        dclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, WACK, SHIFT, DONE, GAP} state_t;

  state_t        state, state_nxt;
  logic [63:0]   sh, sh_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [5:0]    bit_cnt, bit_nxt;
  logic          phase, phase_nxt;
  logic          ncs_r, ncs_nxt;
  logic          dclk_r, dclk_nxt;
  logic          mosi_r, mosi_nxt;
  logic          ack_r, ack_nxt;
  logic [31:0]   dat_r, dat_nxt;
  logic          req;
  logic          unused_ok;

  // Flash byte at addr+k was received k-th, MSB first; it belongs in lane k.
  function automatic logic [31:0] flash_word(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  assign req       = wb_cyc_i & wb_stb_i;
  assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24], wb_adr_i[1:0]};

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    div_nxt   = div_cnt;
    gap_nxt   = gap_cnt;
    bit_nxt   = bit_cnt;
    phase_nxt = phase;
    ncs_nxt   = 1'b1;
    dclk_nxt  = 1'b0;
    mosi_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    dat_nxt   = dat_r;
    unique case (state)
      IDLE: begin
        if (req && wb_we_i) begin
          state_nxt = WACK;
          ack_nxt   = 1'b1;
        end else if (req) begin
          sh_nxt    = {8'h03, wb_adr_i[23:2], 2'b00, 32'h0};
          mosi_nxt  = sh_nxt[63];
          ncs_nxt   = 1'b0;
          div_nxt   = '0;
          bit_nxt   = '0;
          phase_nxt = 1'b0;
          state_nxt = SHIFT;
        end
      end
      WACK: state_nxt = IDLE;
      SHIFT: begin
        if (!req) begin
          // Master gave up: release the flash without acknowledging.
          state_nxt = GAP;
          gap_nxt   = '0;
        end else begin
          ncs_nxt  = 1'b0;
          dclk_nxt = dclk_r;
          mosi_nxt = mosi_r;
          if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            if (!phase) begin
              phase_nxt = 1'b1;
              dclk_nxt  = 1'b1;
              sh_nxt    = {sh[62:0], miso};
            end else begin
              phase_nxt = 1'b0;
              dclk_nxt  = 1'b0;
              if (bit_cnt == 6'd63) begin
                state_nxt = DONE;
                ncs_nxt   = 1'b1;
                mosi_nxt  = 1'b0;
                ack_nxt   = 1'b1;
                dat_nxt   = flash_word(sh[31:0]);
              end else begin
                bit_nxt  = bit_cnt + 6'd1;
                mosi_nxt = sh[63];
              end
            end
          end else begin
            div_nxt = div_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = GAP;
        gap_nxt   = '0;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      sh      <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      ncs_r   <= 1'b1;
      dclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      ack_r   <= 1'b0;
      dat_r   <= '0;
    end else begin
      state   <= state_nxt;
      sh      <= sh_nxt;
      div_cnt <= div_nxt;
      gap_cnt <= gap_nxt;
      bit_cnt <= bit_nxt;
      phase   <= phase_nxt;
      ncs_r   <= ncs_nxt;
      dclk_r  <= dclk_nxt;
      mosi_r  <= mosi_nxt;
      ack_r   <= ack_nxt;
      dat_r   <= dat_nxt;
    end
  end

  // A master that drops cyc in the ack cycle never sees a stray ack.
  assign wb_ack_o = ack_r & wb_cyc_i;
  assign wb_dat_o = dat_r;
  assign ncs      = ncs_r;
  assign dclk     = dclk_r;
  assign mosi     = mosi_r;

endmodule
